if_stage: RTL and testbench

- Instruction-fetch stage of the RV32I pipeline, directly upstream of the IF/ID boundary.
- Owns the PC and issues instruction-memory reads.
- Statically predicts JAL and conditional branches and presents one instruction per cycle downstream, as an rv32i_pc_word plus an rv32i_brp_word with a valid/stall handshake.
- Consumes execute-stage redirects on misprediction.

---
 rtl/if_stage.sv | 190 +++++++++++++++++++
 tb/tb_if_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage : RV32I instruction-fetch stage.
//   Owns the PC and issues instruction-memory reads. JAL and conditional
//   branches are predicted statically. One instruction per cycle is presented
//   downstream through an output register backed by a one-entry skid buffer.
//   Execute-stage redirects flush both registers and restart fetch.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   stall_i        downstream not accepting this cycle
//   redirect_i     redirect from execute (highest priority)
//   redirect_pc_i  corrected fetch address
//   imem_read      read request (held until imem_resp)
//   imem_address   word-aligned read address (held until imem_resp)
//   imem_rdata     instruction word, valid with imem_resp
//   imem_resp      one-cycle response strobe
//   if_valid       output register holds a live instruction
//   if_pc_word     {pc, predicted next pc, instr}
//   if_brp_word    static prediction information
// -----------------------------------------------------------------------------
package if_stage_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_wdata;
    logic [31:0] instr;
  } rv32i_pc_word;

  typedef struct packed {
    logic        predicted;
    logic        prediction;
    logic [31:0] brp_target;
    logic [31:0] brp_alt;
    logic        mp_valid;
    logic        mispredicted;
  } rv32i_brp_word;
endpackage

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic          redirect_i,
  input  logic [31:0]   redirect_pc_i,
  output logic          imem_read,
  output logic [31:0]   imem_address,
  input  logic [31:0]   imem_rdata,
  input  logic          imem_resp,
  output logic          if_valid,
  output rv32i_pc_word  if_pc_word,
  output rv32i_brp_word if_brp_word
);

  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, DISCARD = 2'd2} state_t;

  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  state_t        r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_old_addr;   // address of the request being drained in DISCARD
  logic          r_valid;
  rv32i_pc_word  r_out_pc;
  rv32i_brp_word r_out_brp;
  rv32i_pc_word  r_skid_pc;    // skid is occupied exactly when r_state == HOLD
  rv32i_brp_word r_skid_brp;

  logic [31:0]   w_j_imm, w_b_imm, w_pc4, w_pc_j, w_pc_b;
  logic [6:0]    w_op;
  logic          w_accept;
  rv32i_brp_word w_brp;
  rv32i_pc_word  w_pcw;

  // ---------------------------------------------------------------------------
  // Static prediction on the returned word
  // ---------------------------------------------------------------------------
  assign w_op    = imem_rdata[6:0];
  assign w_j_imm = {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
                    imem_rdata[30:21], 1'b0};
  assign w_b_imm = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
                    imem_rdata[11:8], 1'b0};
  assign w_pc4   = r_pc + 32'd4;
  assign w_pc_j  = r_pc + w_j_imm;
  assign w_pc_b  = r_pc + w_b_imm;

  always_comb begin
    w_brp            = '0;
    w_brp.brp_target = w_pc4;
    w_brp.brp_alt    = w_pc4;
    if (w_op == OP_JAL) begin
      w_brp.predicted  = 1'b1;
      w_brp.prediction = 1'b1;
      w_brp.brp_target = w_pc_j;
    end else if (w_op == OP_BR) begin
      w_brp.predicted = 1'b1;
      // backward taken, forward not taken
      if (w_b_imm[31]) begin
        w_brp.prediction = 1'b1;
        w_brp.brp_target = w_pc_b;
      end else begin
        w_brp.brp_alt    = w_pc_b;
      end
    end
  end

  always_comb begin
    w_pcw          = '0;
    w_pcw.pc       = r_pc;
    w_pcw.pc_wdata = w_brp.brp_target;
    w_pcw.instr    = imem_rdata;
  end

  assign w_accept = r_valid & ~stall_i;

  // ---------------------------------------------------------------------------
  // Memory interface: DISCARD keeps the abandoned address on the bus until the
  // response arrives, while r_pc already holds the redirect target.
  // ---------------------------------------------------------------------------
  assign imem_read    = rst & (r_state != HOLD);
  assign imem_address = (r_state == DISCARD) ? {r_old_addr[31:2], 2'b00}
                                             : {r_pc[31:2], 2'b00};

  assign if_valid    = r_valid;
  assign if_pc_word  = r_out_pc;
  assign if_brp_word = r_out_brp;

  // ---------------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_old_addr <= '0;
      r_valid    <= 1'b0;
      r_out_pc   <= '0;
      r_out_brp  <= '0;
      r_skid_pc  <= '0;
      r_skid_brp <= '0;
    end else if (redirect_i) begin
      r_valid    <= 1'b0;
      r_skid_pc  <= '0;
      r_skid_brp <= '0;
      r_pc       <= redirect_pc_i;
      case (r_state)
        FETCH: if (!imem_resp) begin
          r_state    <= DISCARD;
          r_old_addr <= r_pc;
        end
        HOLD:    r_state <= FETCH;
        DISCARD: if (imem_resp) r_state <= FETCH;
        default: r_state <= FETCH;
      endcase
    end else begin
      case (r_state)
        FETCH: begin
          if (w_accept) r_valid <= 1'b0;
          if (imem_resp) begin
            r_pc <= w_brp.brp_target;
            if (!r_valid || w_accept) begin
              r_valid   <= 1'b1;
              r_out_pc  <= w_pcw;
              r_out_brp <= w_brp;
            end else begin
              r_skid_pc  <= w_pcw;
              r_skid_brp <= w_brp;
              r_state    <= HOLD;
            end
          end
        end
        HOLD: if (w_accept) begin
          r_out_pc  <= r_skid_pc;
          r_out_brp <= r_skid_brp;
          r_valid   <= 1'b1;
          r_state   <= FETCH;
        end
        DISCARD: begin
          if (w_accept) r_valid <= 1'b0;
          if (imem_resp) r_state <= FETCH;
        end
        default: r_state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage : directed + randomized bench for if_stage.
//   A memory model answers requests with configurable latency. Every memory
//   word is recorded with its kind (jal/branch/other) and offset, so expected
//   prediction results come from those recorded facts rather than decoding.
//   The expected delivered stream is the architectural fetch chain: start at
//   the reset or redirect PC and follow the predicted target.
// -----------------------------------------------------------------------------
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] RPC = 32'h4000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall_i = 1'b0;
  logic          redirect_i = 1'b0;
  logic [31:0]   redirect_pc_i = '0;
  logic          imem_read;
  logic [31:0]   imem_address;
  logic [31:0]   imem_rdata = '0;
  logic          imem_resp = 1'b0;
  logic          if_valid;
  rv32i_pc_word  if_pc_word;
  rv32i_brp_word if_brp_word;

  if_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_read(imem_read),
    .imem_address(imem_address), .imem_rdata(imem_rdata),
    .imem_resp(imem_resp), .if_valid(if_valid), .if_pc_word(if_pc_word),
    .if_brp_word(if_brp_word)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // memory model: raw word, kind (0 other, 1 jal, 2 branch), byte offset
  logic [31:0] raw_m  [logic [31:0]];
  int          kind_m [logic [31:0]];
  int          off_m  [logic [31:0]];
  bit          gen_rand = 0;
  bit          rand_lat = 0;
  int          lat = 0;
  int          wcnt = 0;

  logic [31:0] exp_pc = RPC;
  bit          p_read = 0;
  bit          p_resp = 0;
  logic [31:0] p_addr = '0;
  int          delivered = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_jal(input int off);
    logic [31:0] o;
    o = off;
    return {o[20], o[10:1], o[11], o[19:12], 5'd0, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_br(input int off);
    logic [31:0] o;
    o = off;
    return {o[12], o[10:5], 5'd0, 5'd0, 3'b000, o[4:1], o[11], 7'b1100011};
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] r, input int k, input int off);
    raw_m[a] = r; kind_m[a] = k; off_m[a] = off;
  endtask

  task automatic ensure(input logic [31:0] a);
    int s, k, off;
    logic [31:0] r, u;
    if (!raw_m.exists(a)) begin
      k = 0; off = 0; r = 32'h0000_0013;
      if (gen_rand) begin
        s   = $urandom_range(0, 9);
        off = (int'($urandom_range(0, 31)) - 16) * 4;
        u   = $urandom;
        if (s < 2)       begin k = 1; r = enc_jal(off); end
        else if (s < 5)  begin k = 2; r = enc_br(off); end
        else if (s == 5) begin k = 0; r = 32'h0000_80E7; end
        else             begin k = 0; r = {u[31:20], 5'd1, 3'b000, 5'd1, 7'b0010011}; end
      end
      put(a, r, k, off);
    end
  endtask

  function automatic rv32i_brp_word exp_brp(input logic [31:0] pc);
    rv32i_brp_word b;
    logic [31:0] o;
    int k;
    k = kind_m.exists(pc) ? kind_m[pc] : 0;
    o = off_m.exists(pc) ? off_m[pc] : 0;
    b = '0;
    b.brp_target = pc + 32'd4;
    b.brp_alt    = pc + 32'd4;
    if (k == 1 || (k == 2 && $signed(o) < 0)) begin
      b.predicted = 1'b1; b.prediction = 1'b1; b.brp_target = pc + o;
    end else if (k == 2) begin
      b.predicted = 1'b1; b.brp_alt = pc + o;
    end
    return b;
  endfunction

  // one cycle of stimulus, memory response, protocol check and scoreboard
  task automatic drive(input bit st, input bit rd, input logic [31:0] rpc);
    rv32i_brp_word eb;
    rv32i_pc_word  ep;
    stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
    if (p_read && !p_resp) begin
      chk("req_held", 128'(imem_read), 128'(1));
      chk("addr_held", 128'(imem_address), 128'(p_addr));
    end
    imem_resp = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    if (imem_read) begin
      if (wcnt >= lat) begin
        ensure(imem_address);
        imem_rdata = raw_m[imem_address];
        imem_resp = 1'b1;
        wcnt = 0;
        if (rand_lat) lat = $urandom_range(0, 2);
      end else wcnt++;
    end
    p_read = imem_read; p_resp = imem_resp; p_addr = imem_address;
    if (if_valid && !st && !rd) begin
      eb = exp_brp(exp_pc);
      ep.pc = exp_pc; ep.pc_wdata = eb.brp_target;
      ep.instr = raw_m.exists(exp_pc) ? raw_m[exp_pc] : 32'h0;
      chk("out_pc_word", 128'(if_pc_word), 128'(ep));
      chk("out_brp", 128'(if_brp_word), 128'(eb));
      exp_pc = eb.brp_target;
      delivered++;
    end
    if (rd) exp_pc = rpc;
  endtask

  task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc);
    @(negedge clk);
    drive(st, rd, rpc);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
    p_read = 0; p_resp = 0; wcnt = 0; lat = 0; exp_pc = RPC;
    #1;
    chk("first_req_read", 128'(imem_read), 128'(1));
    chk("first_req_addr", 128'(imem_address), 128'(RPC));
    drive(1'b0, 1'b0, 32'h0);
  endtask

  task automatic find_fetch(input logic [31:0] a, input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (imem_read && imem_resp && imem_address == a) found = 1;
    end
    chk(tag, 128'(found), 128'(1));
  endtask

  initial begin
    logic [31:0] a_old;
    int d0;
    bit got;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_valid", 128'(if_valid), 128'(0));
    chk("rst_read", 128'(imem_read), 128'(0));
    chk("rst_pc_word", 128'(if_pc_word), 128'(0));
    chk("rst_brp_word", 128'(if_brp_word), 128'(0));

    // ---- NOP stream, single-cycle memory ----
    release_rst();
    cycle(0, 0, 0);
    chk("nop_c2_valid", 128'(if_valid), 128'(1));
    chk("nop_c2_pc", 128'(if_pc_word.pc), 128'(RPC));
    chk("nop_c2_wdata", 128'(if_pc_word.pc_wdata), 128'(RPC + 4));
    chk("nop_c2_pred", 128'(if_brp_word.predicted), 128'(0));
    chk("nop_c2_addr", 128'(imem_address), 128'(RPC + 4));
    cycle(0, 0, 0);
    chk("nop_c3_addr", 128'(imem_address), 128'(RPC + 8));
    chk("nop_c3_pc", 128'(if_pc_word.pc), 128'(RPC + 4));

    // ---- JAL +16 at reset PC ----
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    put(RPC, 32'h0100_006F, 1, 16);
    release_rst();
    cycle(0, 0, 0);
    chk("jal_next_req", 128'(imem_address), 128'(32'h4000_0010));
    chk("jal_target", 128'(if_brp_word.brp_target), 128'(32'h4000_0010));
    chk("jal_alt", 128'(if_brp_word.brp_alt), 128'(32'h4000_0004));
    chk("jal_prediction", 128'(if_brp_word.prediction), 128'(1));
    chk("jal_wdata", 128'(if_pc_word.pc_wdata), 128'(32'h4000_0010));

    // ---- backward branch -8 at 0x40000020 ----
    put(32'h4000_0020, enc_br(-8), 2, -8);
    cycle(0, 1, 32'h4000_0020);
    find_fetch(32'h4000_0020, "bwd_fetched");
    cycle(0, 0, 0);
    chk("bwd_next_req", 128'(imem_address), 128'(32'h4000_0018));
    chk("bwd_pc", 128'(if_pc_word.pc), 128'(32'h4000_0020));
    chk("bwd_prediction", 128'(if_brp_word.prediction), 128'(1));
    chk("bwd_alt", 128'(if_brp_word.brp_alt), 128'(32'h4000_0024));

    // ---- forward branch +12 at 0x40000020 ----
    put(32'h4000_0020, enc_br(12), 2, 12);
    cycle(0, 1, 32'h4000_0020);
    find_fetch(32'h4000_0020, "fwd_fetched");
    cycle(0, 0, 0);
    chk("fwd_next_req", 128'(imem_address), 128'(32'h4000_0024));
    chk("fwd_prediction", 128'(if_brp_word.prediction), 128'(0));
    chk("fwd_predicted", 128'(if_brp_word.predicted), 128'(1));
    chk("fwd_alt", 128'(if_brp_word.brp_alt), 128'(32'h4000_002C));

    // ---- 5-cycle stall with responses arriving ----
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0);
      chk("stall_valid", 128'(if_valid), 128'(1));
      chk("stall_out_pc", 128'(if_pc_word.pc), 128'(exp_pc));
    end
    chk("stall_read_off", 128'(imem_read), 128'(0));
    d0 = delivered;
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("stall_drain", 128'(delivered), 128'(d0 + 2));
    chk("stall_refetch", 128'(imem_read), 128'(1));

    // ---- redirect while a slow request is outstanding ----
    cycle(0, 0, 0);
    lat = 3;
    cycle(0, 0, 0);
    a_old = imem_address;
    cycle(0, 1, 32'h4000_1000);
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      cycle(0, 0, 0);
      chk("disc_valid", 128'(if_valid), 128'(0));
      chk("disc_addr", 128'(imem_address), 128'(a_old));
      chk("disc_read", 128'(imem_read), 128'(1));
      if (imem_resp) got = 1;
    end
    chk("disc_resp_seen", 128'(got), 128'(1));
    lat = 0;
    cycle(0, 0, 0);
    chk("redir_req", 128'(imem_address), 128'(32'h4000_1000));
    chk("redir_valid", 128'(if_valid), 128'(0));
    cycle(0, 0, 0);
    chk("redir_out_valid", 128'(if_valid), 128'(1));
    chk("redir_out_pc", 128'(if_pc_word.pc), 128'(32'h4000_1000));

    // ---- asynchronous reset in HOLD ----
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);
    chk("hold_read", 128'(imem_read), 128'(0));
    chk("hold_valid", 128'(if_valid), 128'(1));
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 128'(if_valid), 128'(0));
    chk("arst_read", 128'(imem_read), 128'(0));
    chk("arst_pc_word", 128'(if_pc_word), 128'(0));
    stall_i = 1'b0;
    @(negedge clk);
    release_rst();
    cycle(0, 0, 0);
    chk("arst_restart_pc", 128'(if_pc_word.pc), 128'(RPC));

    // ---- randomized traffic ----
    gen_rand = 1; rand_lat = 1;
    cycle(0, 1, 32'h4000_2000);
    d0 = delivered;
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 49) == 0,
            32'h4000_2000 + 32'($urandom_range(0, 255)) * 32'd4);
    end
    chk("rand_progress", 128'(delivered - d0 > 300), 128'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
